// File: rtl/vproc_sld_wb.sv
// Packs in-order slide-unit result chunks into one masked vector-register write.
// Write presents 1 cycle after the flushing chunk; chunk intake stalls only while a write waits on wr_ready_i.
module vproc_sld_wb #(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned SLD_OP_W = 64,
  parameter int unsigned VADDR_W  = 5,
  parameter int unsigned CNT_W    = $clog2(VREG_W / SLD_OP_W)
) (
  input  logic                    clk_i,
  input  logic                    async_rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [VADDR_W-1:0]      in_vd_i,
  input  logic [CNT_W-1:0]        in_count_i,
  input  logic                    in_last_i,
  input  logic [SLD_OP_W-1:0]     in_res_i,
  input  logic [SLD_OP_W/8-1:0]   in_mask_i,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic [VADDR_W-1:0]      wr_addr_o,
  output logic [VREG_W-1:0]       wr_data_o,
  output logic [VREG_W/8-1:0]     wr_be_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned NCHUNK = VREG_W / SLD_OP_W;
  localparam int unsigned CB     = SLD_OP_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NCHUNK - 1);

  typedef enum logic {COLLECT, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VADDR_W-1:0]   vd_q, vd_d;
  logic [VREG_W-1:0]    data_q, data_d;
  logic [VREG_W/8-1:0]  be_q, be_d;
  logic                 err_q, err_d;
  logic                 in_hs;
  logic                 wr_hs;

  // In FLUSH a new chunk may enter only in the cycle the pending write retires.
  assign in_ready_o = (state_q == COLLECT) | wr_ready_i;
  assign in_hs      = in_valid_i & in_ready_o;
  assign wr_hs      = (state_q == FLUSH) & wr_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vd_d    = vd_q;
    data_d  = data_q;
    be_d    = be_q;
    err_d   = err_q;

    // Retiring write empties the buffer first so an overlapping chunk starts fresh.
    if (wr_hs) begin
      state_d = COLLECT;
      cnt_d   = '0;
      data_d  = '0;
      be_d    = '0;
    end

    if (in_hs) begin
      if (in_count_i == cnt_d) begin
        for (int unsigned c = 0; c < NCHUNK; c++) begin
          if (CNT_W'(c) == cnt_d) begin
            for (int unsigned b = 0; b < CB; b++) begin
              if (in_mask_i[b]) begin
                data_d[c*SLD_OP_W + b*8 +: 8] = in_res_i[b*8 +: 8];
                be_d[c*CB + b]                = 1'b1;
              end
            end
          end
        end
        if (cnt_d == '0) begin
          vd_d = in_vd_i;
        end
        if ((cnt_d == CNT_MAX) || in_last_i) begin
          cnt_d = '0;
          if (|be_d) begin
            state_d = FLUSH;
          end else begin
            data_d = '0;
            be_d   = '0;
          end
        end else begin
          cnt_d = cnt_d + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      vd_q    <= '0;
      data_q  <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vd_q    <= vd_d;
      data_q  <= data_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  assign wr_valid_o = (state_q == FLUSH);
  assign wr_addr_o  = vd_q;
  assign wr_data_o  = data_q;
  assign wr_be_o    = be_q;
  assign busy_o     = (state_q == FLUSH) | (cnt_q != '0);
  assign err_o      = err_q;

endmodule

// File: doc/vproc_sld_wb.md
Name: vproc_sld_wb

Overview:
- Writeback packer directly downstream of the slide unit.
- Collects SLD_OP_W-wide result chunks, each with a byte mask, in order. Assembles them into one VREG_W-wide vector-register write with per-byte enables.
- Issues the write through a valid/ready port to the register file.
- Tracks the expected chunk index and flags out-of-order chunks.

Parameters:
VREG_W, 128, vector register width in bits
SLD_OP_W, 64, chunk width in bits; VREG_W/SLD_OP_W >= 2, power of two
VADDR_W, 5, vector register address width
CNT_W, derived $clog2(VREG_W/SLD_OP_W), chunk index width

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  chunk valid
in_ready_o  out  1  chunk accepted when valid & ready
in_vd_i  in  VADDR_W  destination register of chunk
in_count_i  in  CNT_W  chunk index within register
in_last_i  in  1  final chunk of the instruction
in_res_i  in  SLD_OP_W  result data
in_mask_i  in  SLD_OP_W/8  byte write mask
wr_valid_o  out  1  register write request
wr_ready_i  in  1  register file accepts write
wr_addr_o  out  VADDR_W  write address
wr_data_o  out  VREG_W  write data
wr_be_o  out  VREG_W/8  write byte enables
busy_o  out  1  buffer holds data or write pending
err_o  out  1  sticky out-of-order chunk flag

Behaviour:
- Reset (async, active-low) sets:
  - state=COLLECT, expected count=0, vd=0, data buffer=0, be buffer=0
  - wr_valid_o=0, busy_o=0, err_o=0
  - in_ready_o=1 once reset is released
- Reset mid-operation discards the partial buffer and any pending write. No write is issued after reset.
- COLLECT state:
  - in_ready_o=1.
  - On an accepted chunk with in_count_i==expected count:
    - Write in_res_i bytes into buffer slice [count*SLD_OP_W +: SLD_OP_W], only where in_mask_i=1.
    - OR in_mask_i into be slice [count*SLD_OP_W/8 +: SLD_OP_W/8].
    - If count==0, latch vd from in_vd_i. Later chunks ignore in_vd_i.
    - Increment expected count.
  - Flush trigger: count==VREG_W/SLD_OP_W-1, or in_last_i=1.
    - If accumulated be (including this chunk) is nonzero: go to FLUSH. wr_valid_o rises the next cycle (1-cycle latency from last accepted chunk).
    - If accumulated be is all zero: no write. Clear buffer, expected count=0, stay COLLECT.
  - Out-of-order chunk (in_count_i != expected):
    - Chunk is accepted and dropped. Set err_o (sticky until reset).
    - Buffer is left unchanged. The chunk's in_last_i is ignored.
- FLUSH state:
  - wr_valid_o=1; wr_addr_o=latched vd; wr_data_o=buffer; wr_be_o=be buffer.
  - Outputs hold stable while wr_ready_i=0.
  - in_ready_o=wr_ready_i (combinational).
  - On write handshake: clear data/be buffers, set expected count=0, go to COLLECT.
  - Simultaneous handshake and new chunk in the same cycle: the chunk is processed as the first chunk of a fresh buffer, per COLLECT rules. If that chunk itself triggers a flush with nonzero be, stay in FLUSH; the new write presents the next cycle.
- Bytes with be=0 in wr_data_o are 0 (buffer is cleared after each write).
- busy_o = (state==FLUSH) | (expected count != 0).
- Expected count wraps naturally at VREG_W/SLD_OP_W. A flush always resets it to 0.

Test Plan (defaults; 2 chunks, 8-byte masks):
- Full register:
  - Stimulus: chunk0 vd=3, res=0x1111..11, mask=0xFF; then chunk1 res=0x2222..22, mask=0xFF, last=0.
  - Response: the cycle after chunk1, wr_valid_o=1, addr=3, data=0x2222..22_1111..11, be=0xFFFF.
- Partial and masked last:
  - Stimulus: chunk0 mask=0x0F, last=1.
  - Response: write be=0x000F, upper data bytes 0, expected count back to 0.
- All-zero mask:
  - Stimulus: chunk0 mask=0x00, chunk1 mask=0x00.
  - Response: no wr_valid_o, busy_o returns to 0, next chunk0 accepted normally.
- Backpressure with overlap:
  - Stimulus: wr_ready_i=0 for 3 cycles while FLUSH; new chunk0 (vd=7) held valid.
  - Response: in_ready_o=0, outputs stable for 3 cycles. In the cycle wr_ready_i=1, both handshakes occur. The next write carries addr=7.
- Out-of-order:
  - Stimulus: chunk1 sent first.
  - Response: err_o=1 (stays set), buffer unchanged. Subsequent chunk0+chunk1 produce a correct write.
- Reset mid-operation:
  - Stimulus: assert async_rst_ni low after chunk0.
  - Response: immediately wr_valid_o=0, busy_o=0, err_o=0. After release, chunk1 alone flags err_o.
